rf_wb_scoreboard: RTL and testbench
===================================

Name: rf_wb_scoreboard

Overview:
- Issue-side scoreboard and writeback arbiter for the RiSC-16 pipelined core's 8x16 register file (r0 reads as zero, two asynchronous read ports, one write port).
- Tracks which registers have a write in flight and stalls issue of any instruction with a RAW or WAW hazard on them.
- Shares the register file's single write port between two writeback requesters, A (ALU) and B (load unit), using round-robin arbitration.
- Sits between decode/issue and the register file's write port.

Parameters:
p_WORD_LEN, 16, data word width
p_REG_ADDR_LEN, 3, register address width
p_REG_FILE_SIZE, 8, number of registers (r0 hardwired zero)
p_CNT_LEN, 4, width of outstanding-write counter (must hold p_REG_FILE_SIZE-1)

Ports:
i_clk  in  1  clock, all state updates on posedge
i_rst  in  1  asynchronous active-high reset
i_iss_valid  in  1  issue request
i_iss_src1  in  p_REG_ADDR_LEN  source register 1
i_iss_src2  in  p_REG_ADDR_LEN  source register 2
i_iss_tgt  in  p_REG_ADDR_LEN  destination register
i_iss_tgt_we  in  1  instruction writes i_iss_tgt
o_iss_ready  out  1  issue accepted this cycle when high with i_iss_valid
i_wba_valid  in  1  requester A writeback valid
i_wba_tgt  in  p_REG_ADDR_LEN  A destination
i_wba_data  in  p_WORD_LEN  A data
o_wba_ready  out  1  A granted this cycle
i_wbb_valid  in  1  requester B writeback valid
i_wbb_tgt  in  p_REG_ADDR_LEN  B destination
i_wbb_data  in  p_WORD_LEN  B data
o_wbb_ready  out  1  B granted this cycle
o_rf_tgt  out  p_REG_ADDR_LEN  register file write address
o_rf_data  out  p_WORD_LEN  register file write data
o_rf_wr_en  out  1  register file write enable
o_busy  out  p_REG_FILE_SIZE  pending-write bit per register (bit 0 always 0)
o_outstanding  out  p_CNT_LEN  count of set busy bits
o_err  out  1  sticky protocol error flag

Behaviour:
- Reset (asynchronous, i_rst high): busy=0, outstanding=0, err=0, round-robin pointer = A. While in reset, o_iss_ready, o_wba_ready, o_wbb_ready and o_rf_wr_en are all 0.
- Hazard check uses the registered busy vector only; there is no same-cycle bypass from writeback.
- A source or target of r0 never hazards.
- o_iss_ready = !busy[src1] && !busy[src2] && !(i_iss_tgt_we && busy[tgt]). It is combinational and is high even when i_iss_valid=0.
- Issue fire = i_iss_valid && o_iss_ready. On the next posedge, busy[tgt] is set if tgt_we and tgt!=0. tgt_we with tgt=0 changes nothing.
- Arbitration (combinational):
  - Only one requester valid: it is granted.
  - Both valid: the pointer side is granted. After a two-way contention grant, the pointer flips to the other side.
  - Pointer is unchanged when only one requester is valid or neither is.
- Write port:
  - o_rf_wr_en = grant && tgt!=0.
  - o_rf_tgt and o_rf_data are muxed from the granted requester, and are 0 when nothing is granted.
  - The register file commits on the same posedge: zero-cycle latency from grant to write.
- Grant to tgt!=0 clears busy[tgt] at the posedge.
  - Grant to a non-busy tgt!=0 still writes, but sets o_err.
  - Grant to r0 is accepted with no write and no error.
- Issue-set and grant-clear of the same register in one cycle cannot both be legal, because issue requires !busy and clear requires busy. If it occurs anyway (error case): clear wins, busy ends 0, o_err set.
- Issue-set and grant-clear of different registers in the same cycle: both apply. o_outstanding changes by +1-1=0.
- o_outstanding is a registered popcount-equivalent counter (inc on set, dec on legal clear). Saturation is never reached, since at most 7 bits can be set.
- o_err is sticky until reset.
- Reset mid-operation drops all pending state. Subsequent late writebacks to non-busy registers raise o_err.

Test Plan:
- Reset, then issue tgt=r3 we=1 -> next cycle o_busy=8'b00001000, outstanding=1. Issue src1=r3 -> o_iss_ready=0. A writes r3=16'h1234 -> o_rf_wr_en=1, o_rf_tgt=3, o_rf_data=16'h1234; next cycle busy=0 and ready=1.
- WAW: r5 busy, issue tgt=r5 we=1, src=r0 -> o_iss_ready=0. Issue tgt=r0 we=1 -> ready=1 and busy unchanged.
- Contention: r1 and r2 busy, A(r1,16'hAAAA) and B(r2,16'hBBBB) both valid 2 cycles -> cycle0 grants A, cycle1 grants B. r1 and r2 are cleared in order and outstanding goes 2->1->0.
- Single requester: B alone valid 3 cycles to r4/r6/r7 -> granted every cycle, pointer stays at A. A then contends with B -> A wins.
- Error: A writes r2 while busy=0 -> write occurs with o_rf_wr_en=1; o_err=1 and stays 1 until i_rst.
- Async reset asserted mid-cycle with busy=8'b11100000 -> outputs go to reset values immediately without a clock edge, and busy=0 after reset.

Source files
------------

// File: rtl/rf_wb_scoreboard.sv
// Issue-side register scoreboard plus round-robin arbiter sharing the
// register file write port between ALU (A) and load unit (B) writebacks.
module rf_wb_scoreboard #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_REG_ADDR_LEN  = 3,
    parameter int p_REG_FILE_SIZE = 8,
    parameter int p_CNT_LEN       = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_iss_valid,
    input  logic [p_REG_ADDR_LEN-1:0]  i_iss_src1,
    input  logic [p_REG_ADDR_LEN-1:0]  i_iss_src2,
    input  logic [p_REG_ADDR_LEN-1:0]  i_iss_tgt,
    input  logic                       i_iss_tgt_we,
    output logic                       o_iss_ready,
    input  logic                       i_wba_valid,
    input  logic [p_REG_ADDR_LEN-1:0]  i_wba_tgt,
    input  logic [p_WORD_LEN-1:0]      i_wba_data,
    output logic                       o_wba_ready,
    input  logic                       i_wbb_valid,
    input  logic [p_REG_ADDR_LEN-1:0]  i_wbb_tgt,
    input  logic [p_WORD_LEN-1:0]      i_wbb_data,
    output logic                       o_wbb_ready,
    output logic [p_REG_ADDR_LEN-1:0]  o_rf_tgt,
    output logic [p_WORD_LEN-1:0]      o_rf_data,
    output logic                       o_rf_wr_en,
    output logic [p_REG_FILE_SIZE-1:0] o_busy,
    output logic [p_CNT_LEN-1:0]       o_outstanding,
    output logic                       o_err
);

    logic [p_REG_FILE_SIZE-1:0] r_busy;
    logic [p_CNT_LEN-1:0]       r_cnt;
    logic                       r_err;
    logic                       r_ptr;      // 0: A has priority, 1: B

    logic                       w_gnt_a;
    logic                       w_gnt_b;
    logic                       w_gnt;
    logic                       w_fire;
    logic                       w_set;
    logic                       w_clr;
    logic                       w_clr_legal;
    logic                       w_clr_bad;
    logic                       w_set_eff;
    logic [p_REG_FILE_SIZE-1:0] w_set_mask;
    logic [p_REG_FILE_SIZE-1:0] w_clr_mask;
    logic [p_REG_ADDR_LEN-1:0]  w_gnt_tgt;
    logic [p_WORD_LEN-1:0]      w_gnt_data;

    // busy[0] is never set, so r0 sources/targets never hazard
    assign o_iss_ready = !i_rst && !r_busy[i_iss_src1] && !r_busy[i_iss_src2]
                         && !(i_iss_tgt_we && r_busy[i_iss_tgt]);

    assign w_gnt_a = !i_rst && i_wba_valid && (!i_wbb_valid || !r_ptr);
    assign w_gnt_b = !i_rst && i_wbb_valid && (!i_wba_valid || r_ptr);
    assign w_gnt   = w_gnt_a || w_gnt_b;

    always_comb begin
        w_gnt_tgt  = '0;
        w_gnt_data = '0;
        if (w_gnt_a) begin
            w_gnt_tgt  = i_wba_tgt;
            w_gnt_data = i_wba_data;
        end else if (w_gnt_b) begin
            w_gnt_tgt  = i_wbb_tgt;
            w_gnt_data = i_wbb_data;
        end
    end

    assign o_wba_ready = w_gnt_a;
    assign o_wbb_ready = w_gnt_b;
    assign o_rf_tgt    = w_gnt_tgt;
    assign o_rf_data   = w_gnt_data;
    assign o_rf_wr_en  = w_gnt && (w_gnt_tgt != '0);

    assign w_fire      = i_iss_valid && o_iss_ready;
    assign w_set       = w_fire && i_iss_tgt_we && (i_iss_tgt != '0);
    assign w_clr       = o_rf_wr_en;
    assign w_clr_legal = w_clr && r_busy[w_gnt_tgt];
    assign w_clr_bad   = w_clr && !r_busy[w_gnt_tgt];
    // A clear of the register being issued overrides the set
    assign w_set_eff   = w_set && !(w_clr && (w_gnt_tgt == i_iss_tgt));
    assign w_set_mask  = w_set_eff ? (p_REG_FILE_SIZE'(1) << i_iss_tgt) : '0;
    assign w_clr_mask  = w_clr ? (p_REG_FILE_SIZE'(1) << w_gnt_tgt) : '0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_ptr  <= 1'b0;
        end else begin
            r_busy <= (r_busy | w_set_mask) & ~w_clr_mask;
            r_cnt  <= r_cnt + p_CNT_LEN'(w_set_eff) - p_CNT_LEN'(w_clr_legal);
            if (w_clr_bad)
                r_err <= 1'b1;
            if (i_wba_valid && i_wbb_valid)
                r_ptr <= ~r_ptr;
        end
    end

    assign o_busy        = r_busy;
    assign o_outstanding = r_cnt;
    assign o_err         = r_err;

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: expected register-file writes are
// queued by the stimulus and popped by an independent write-port monitor.
module tb_rf_wb_scoreboard;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_iss_valid = 1'b0;
    logic [2:0]  i_iss_src1 = '0;
    logic [2:0]  i_iss_src2 = '0;
    logic [2:0]  i_iss_tgt = '0;
    logic        i_iss_tgt_we = 1'b0;
    logic        o_iss_ready;
    logic        i_wba_valid = 1'b0;
    logic [2:0]  i_wba_tgt = '0;
    logic [15:0] i_wba_data = '0;
    logic        o_wba_ready;
    logic        i_wbb_valid = 1'b0;
    logic [2:0]  i_wbb_tgt = '0;
    logic [15:0] i_wbb_data = '0;
    logic        o_wbb_ready;
    logic [2:0]  o_rf_tgt;
    logic [15:0] o_rf_data;
    logic        o_rf_wr_en;
    logic [7:0]  o_busy;
    logic [3:0]  o_outstanding;
    logic        o_err;

    int checks = 0;
    int failures = 0;
    logic [18:0] exp_q[$];

    rf_wb_scoreboard dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_iss_valid(i_iss_valid), .i_iss_src1(i_iss_src1), .i_iss_src2(i_iss_src2),
        .i_iss_tgt(i_iss_tgt), .i_iss_tgt_we(i_iss_tgt_we), .o_iss_ready(o_iss_ready),
        .i_wba_valid(i_wba_valid), .i_wba_tgt(i_wba_tgt), .i_wba_data(i_wba_data),
        .o_wba_ready(o_wba_ready),
        .i_wbb_valid(i_wbb_valid), .i_wbb_tgt(i_wbb_tgt), .i_wbb_data(i_wbb_data),
        .o_wbb_ready(o_wbb_ready),
        .o_rf_tgt(o_rf_tgt), .o_rf_data(o_rf_data), .o_rf_wr_en(o_rf_wr_en),
        .o_busy(o_busy), .o_outstanding(o_outstanding), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] tgt);
        i_iss_valid = 1'b1; i_iss_tgt = tgt; i_iss_tgt_we = 1'b1;
        i_iss_src1 = 3'd0; i_iss_src2 = 3'd0;
        tick();
        i_iss_valid = 1'b0; i_iss_tgt_we = 1'b0; i_iss_tgt = 3'd0;
    endtask

    // write-port monitor: every enabled write must match the next queued one
    always @(negedge i_clk) begin
        if (o_rf_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {13'd0, o_rf_tgt, o_rf_data}, 32'hFFFF_FFFF);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("wr_tgt", {29'd0, o_rf_tgt}, {29'd0, e[18:16]});
                check("wr_data", {16'd0, o_rf_data}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        #2;
        check("rst_busy", {24'd0, o_busy}, 32'h0);
        check("rst_cnt", {28'd0, o_outstanding}, 32'h0);
        check("rst_err", {31'd0, o_err}, 32'h0);
        check("rst_iss_ready", {31'd0, o_iss_ready}, 32'h0);
        i_wba_valid = 1'b1; i_wba_tgt = 3'd1;
        #1;
        check("rst_wba_ready", {31'd0, o_wba_ready}, 32'h0);
        check("rst_wr_en", {31'd0, o_rf_wr_en}, 32'h0);
        i_wba_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        tick();

        // basic RAW on r3
        issue(3'd3);
        check("busy_r3", {24'd0, o_busy}, 32'h08);
        check("cnt_1", {28'd0, o_outstanding}, 32'd1);
        i_iss_src1 = 3'd3;
        #1 check("raw_stall", {31'd0, o_iss_ready}, 32'h0);
        exp_q.push_back({3'd3, 16'h1234});
        i_wba_valid = 1'b1; i_wba_tgt = 3'd3; i_wba_data = 16'h1234;
        #1 check("a_grant", {31'd0, o_wba_ready}, 32'h1);
        tick();
        i_wba_valid = 1'b0;
        #1;
        check("r3_cleared", {24'd0, o_busy}, 32'h0);
        check("raw_release", {31'd0, o_iss_ready}, 32'h1);
        i_iss_src1 = 3'd0;

        // WAW on r5, r0 target never hazards
        issue(3'd5);
        i_iss_valid = 1'b1; i_iss_tgt = 3'd5; i_iss_tgt_we = 1'b1;
        #1 check("waw_stall", {31'd0, o_iss_ready}, 32'h0);
        i_iss_tgt = 3'd0;
        #1 check("r0_tgt_ready", {31'd0, o_iss_ready}, 32'h1);
        tick();
        i_iss_valid = 1'b0; i_iss_tgt_we = 1'b0;
        check("r0_busy_unchanged", {24'd0, o_busy}, 32'h20);
        check("r0_cnt_unchanged", {28'd0, o_outstanding}, 32'd1);
        exp_q.push_back({3'd5, 16'h5555});
        i_wba_valid = 1'b1; i_wba_tgt = 3'd5; i_wba_data = 16'h5555;
        tick();
        i_wba_valid = 1'b0;

        // two-way contention alternates A then B
        issue(3'd1);
        issue(3'd2);
        check("busy_r1r2", {24'd0, o_busy}, 32'h06);
        check("cnt_2", {28'd0, o_outstanding}, 32'd2);
        exp_q.push_back({3'd1, 16'hAAAA});
        exp_q.push_back({3'd2, 16'hBBBB});
        i_wba_valid = 1'b1; i_wba_tgt = 3'd1; i_wba_data = 16'hAAAA;
        i_wbb_valid = 1'b1; i_wbb_tgt = 3'd2; i_wbb_data = 16'hBBBB;
        #1 check("cont0_grants", {30'd0, o_wba_ready, o_wbb_ready}, 32'b10);
        tick();
        check("cont0_busy", {24'd0, o_busy}, 32'h04);
        check("cont0_cnt", {28'd0, o_outstanding}, 32'd1);
        check("cont1_grants", {30'd0, o_wba_ready, o_wbb_ready}, 32'b01);
        tick();
        i_wba_valid = 1'b0; i_wbb_valid = 1'b0;
        check("cont1_busy", {24'd0, o_busy}, 32'h0);
        check("cont1_cnt", {28'd0, o_outstanding}, 32'd0);

        // B alone three cycles; pointer must stay on A
        issue(3'd4);
        issue(3'd6);
        issue(3'd7);
        check("cnt_3", {28'd0, o_outstanding}, 32'd3);
        for (int k = 0; k < 3; k++) begin
            logic [2:0] t;
            t = (k == 0) ? 3'd4 : (k == 1) ? 3'd6 : 3'd7;
            exp_q.push_back({t, 16'hB000 + 16'(k)});
            i_wbb_valid = 1'b1; i_wbb_tgt = t; i_wbb_data = 16'hB000 + 16'(k);
            #1 check("b_alone_grant", {31'd0, o_wbb_ready}, 32'h1);
            tick();
        end
        i_wbb_valid = 1'b0;
        check("b_alone_busy", {24'd0, o_busy}, 32'h0);
        issue(3'd1);
        issue(3'd2);
        exp_q.push_back({3'd1, 16'h1111});
        exp_q.push_back({3'd2, 16'h2222});
        i_wba_valid = 1'b1; i_wba_tgt = 3'd1; i_wba_data = 16'h1111;
        i_wbb_valid = 1'b1; i_wbb_tgt = 3'd2; i_wbb_data = 16'h2222;
        #1 check("ptr_kept_a_wins", {30'd0, o_wba_ready, o_wbb_ready}, 32'b10);
        tick();
        i_wba_valid = 1'b0;
        tick();
        i_wbb_valid = 1'b0;
        check("err_still_0", {31'd0, o_err}, 32'h0);

        // issue-set and clear of different registers in one cycle
        issue(3'd4);
        exp_q.push_back({3'd4, 16'h4444});
        i_wba_valid = 1'b1; i_wba_tgt = 3'd4; i_wba_data = 16'h4444;
        issue(3'd5);
        i_wba_valid = 1'b0;
        check("setclr_busy", {24'd0, o_busy}, 32'h20);
        check("setclr_cnt", {28'd0, o_outstanding}, 32'd1);
        exp_q.push_back({3'd5, 16'h5A5A});
        i_wba_valid = 1'b1; i_wba_tgt = 3'd5; i_wba_data = 16'h5A5A;
        tick();
        i_wba_valid = 1'b0;

        // write to r0 accepted silently
        i_wbb_valid = 1'b1; i_wbb_tgt = 3'd0; i_wbb_data = 16'hFFFF;
        #1 check("r0_wb_grant_no_wr", {30'd0, o_wbb_ready, o_rf_wr_en}, 32'b10);
        tick();
        i_wbb_valid = 1'b0;
        check("r0_wb_no_err", {31'd0, o_err}, 32'h0);

        // write to non-busy register raises sticky error
        exp_q.push_back({3'd2, 16'hDEAD});
        i_wba_valid = 1'b1; i_wba_tgt = 3'd2; i_wba_data = 16'hDEAD;
        #1 check("err_wr_en", {31'd0, o_rf_wr_en}, 32'h1);
        tick();
        i_wba_valid = 1'b0;
        check("err_set", {31'd0, o_err}, 32'h1);
        tick(); tick();
        check("err_sticky", {31'd0, o_err}, 32'h1);
        check("err_cnt_unchanged", {28'd0, o_outstanding}, 32'd0);

        // async reset mid-cycle with r5..r7 busy
        issue(3'd5);
        issue(3'd6);
        issue(3'd7);
        check("busy_e0", {24'd0, o_busy}, 32'hE0);
        #2;
        i_rst = 1'b1;
        i_wba_valid = 1'b1; i_wba_tgt = 3'd2; i_wba_data = 16'hCAFE;
        #1;
        check("async_busy", {24'd0, o_busy}, 32'h0);
        check("async_cnt", {28'd0, o_outstanding}, 32'd0);
        check("async_err", {31'd0, o_err}, 32'h0);
        check("async_readies", {29'd0, o_iss_ready, o_wba_ready, o_rf_wr_en}, 32'b000);
        tick();
        i_rst = 1'b0;
        exp_q.push_back({3'd2, 16'hCAFE});
        tick();
        i_wba_valid = 1'b0;
        check("late_wb_err", {31'd0, o_err}, 32'h1);
        check("late_wb_busy", {24'd0, o_busy}, 32'h0);

        tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
